// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-side arbiter.
//   arb_state_e : two-state arbiter FSM encoding (ST_IDLE / ST_GRANT)
//   arb_clog2   : index width for a requester count (minimum 1 bit)
package fifo_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  function automatic int unsigned arb_clog2(input int unsigned n);
    int unsigned w;
    w = 0;
    for (int unsigned v = 1; v < n; v = v << 1) begin
      w = w + 1;
    end
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_arb_pick.sv
// Round-robin requester picker (purely combinational).
//   req_valid  in  NUM_REQ  per-requester valid
//   last_owner in  REQ_W    most recent owner; search starts at last_owner+1
//   pick       out REQ_W    first valid index at or after last_owner+1 (mod NUM_REQ)
//   any        out 1        at least one requester valid
module rr_arb_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned REQ_W   = arb_clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [REQ_W-1:0]   last_owner,
  output logic [REQ_W-1:0]   pick,
  output logic               any
);

  int unsigned idx;

  // Offsets 1..NUM_REQ visit every lane once, ending on last_owner itself.
  always_comb begin
    pick = '0;
    any  = 1'b0;
    idx  = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(last_owner) + k) % NUM_REQ;
      if (!any && req_valid[idx[REQ_W-1:0]]) begin
        any  = 1'b1;
        pick = idx[REQ_W-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter sharing one FIFO write port between NUM_REQ
// producers, with a registered write stage and combinational full throttling.
// Build option: define FIFO_ARB_BURST_EN for bursts of up to MAX_BURST words
// per grant (ended early by req_last); otherwise each grant carries one word.
//   wr_clk      in  1                   clock
//   reset       in  1                   synchronous, active-high
//   req_valid   in  NUM_REQ             lane i holds a word
//   req_data    in  NUM_REQ*WORD_WIDTH  lane i at [i*WORD_WIDTH +: WORD_WIDTH]
//   req_last    in  NUM_REQ             word on lane i ends its burst
//   req_ready   out NUM_REQ             combinational accept, one-hot or zero
//   fifo_full   in  1                   FIFO full flag
//   fifo_wr_en  out 1                   registered FIFO write enable
//   fifo_din    out WORD_WIDTH          registered FIFO write data
//   grant_id    out REQ_W               current / most recent owner
//   busy        out 1                   high while in GRANT
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned REQ_W      = arb_clog2(NUM_REQ),
  parameter int unsigned MAX_BURST  = 8,
  parameter int unsigned BURST_W    = 4
) (
  input  logic                          wr_clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*WORD_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [WORD_WIDTH-1:0]         fifo_din,
  output logic [REQ_W-1:0]              grant_id,
  output logic                          busy
);

  arb_state_e             state_q, state_d;
  logic [REQ_W-1:0]       owner_q, owner_d;
  logic [REQ_W-1:0]       last_owner_q, last_owner_d;
  logic [REQ_W-1:0]       pick;
  logic                   any;
  logic                   owner_valid;
  logic [WORD_WIDTH-1:0]  owner_data;
  logic                   accept;
  logic                   release_grant;
  logic                   burst_end;

`ifdef FIFO_ARB_BURST_EN
  logic [BURST_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic                   owner_last;

  assign burst_end = owner_last ||
                     ((beat_cnt_q + BURST_W'(1)) == BURST_W'(MAX_BURST));
`else
  logic                   unused_cfg;

  assign burst_end  = 1'b1;
  assign unused_cfg = ^{req_last, BURST_W'(MAX_BURST)};
`endif

  rr_arb_pick #(
    .NUM_REQ (NUM_REQ),
    .REQ_W   (REQ_W)
  ) u_pick (
    .req_valid  (req_valid),
    .last_owner (last_owner_q),
    .pick       (pick),
    .any        (any)
  );

  // Owner lane select.
  always_comb begin
    owner_valid = 1'b0;
    owner_data  = '0;
`ifdef FIFO_ARB_BURST_EN
    owner_last  = 1'b0;
`endif
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (owner_q == REQ_W'(i)) begin
        owner_valid = req_valid[i];
        owner_data  = req_data[i*WORD_WIDTH +: WORD_WIDTH];
`ifdef FIFO_ARB_BURST_EN
        owner_last  = req_last[i];
`endif
      end
    end
  end

  // State register plus registered write stage.
  always_ff @(posedge wr_clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      last_owner_q <= REQ_W'(NUM_REQ - 1);
      fifo_wr_en   <= 1'b0;
      fifo_din     <= '0;
`ifdef FIFO_ARB_BURST_EN
      beat_cnt_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      fifo_wr_en   <= accept;
      if (accept) begin
        fifo_din <= owner_data;
      end
`ifdef FIFO_ARB_BURST_EN
      beat_cnt_q   <= beat_cnt_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
`ifdef FIFO_ARB_BURST_EN
    beat_cnt_d   = beat_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (any) begin
          state_d = ST_GRANT;
          owner_d = pick;
`ifdef FIFO_ARB_BURST_EN
          beat_cnt_d = '0;
`endif
        end
      end
      ST_GRANT: begin
`ifdef FIFO_ARB_BURST_EN
        if (accept) begin
          beat_cnt_d = beat_cnt_q + BURST_W'(1);
        end
`endif
        if (release_grant) begin
          state_d      = ST_IDLE;
          last_owner_d = owner_q;
        end
      end
    endcase
  end

  // Outputs. A dropped valid releases even while full; a full stall holds owner.
  always_comb begin
    busy          = (state_q == ST_GRANT);
    accept        = busy && owner_valid && !fifo_full;
    release_grant = busy && (!owner_valid || (accept && burst_end));
    req_ready     = '0;
    if (busy && !fifo_full) begin
      req_ready[owner_q] = 1'b1;
    end
  end

  assign grant_id = owner_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int WW = 16;

`ifdef FIFO_ARB_BURST_EN
  localparam int S0_WORDS = 8;
  localparam int S0_STEPS = 37;
  localparam int S1_SPAN  = 2;
`else
  localparam int S0_WORDS = 2;
  localparam int S0_STEPS = 17;
  localparam int S1_SPAN  = 4;
`endif

  logic              wr_clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req_valid;
  logic [NR*WW-1:0]  req_data;
  logic [NR-1:0]     req_last;
  logic [NR-1:0]     req_ready;
  logic              fifo_full;
  logic              fifo_wr_en;
  logic [WW-1:0]     fifo_din;
  logic [1:0]        grant_id;
  logic              busy;

  fifo_wr_arbiter #(
    .NUM_REQ    (4),
    .WORD_WIDTH (16),
    .REQ_W      (2),
    .MAX_BURST  (8),
    .BURST_W    (4)
  ) dut (
    .wr_clk     (wr_clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  always #5 wr_clk = ~wr_clk;

  typedef struct { logic [WW-1:0] d; logic l; } word_t;
  typedef struct { logic [1:0] id; logic [WW-1:0] d; } exp_t;

  word_t pq[NR][$];
  exp_t  exp_q[$];

  int checks   = 0;
  int errors   = 0;
  int wr_count = 0;

  logic          reset_drv = 1'b1;
  logic          full_drv  = 1'b0;
  logic          obs_wr, obs_busy;
  logic [WW-1:0] obs_din;
  logic [1:0]    obs_gid;
  logic [NR-1:0] obs_rdy, xfer;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_word(input int r, input logic [WW-1:0] d, input logic l);
    word_t w;
    w.d = d;
    w.l = l;
    pq[r].push_back(w);
  endtask

  task automatic expect_wr(input int r, input logic [WW-1:0] d);
    exp_t e;
    e.id = 2'(r);
    e.d  = d;
    exp_q.push_back(e);
  endtask

  function automatic logic [WW-1:0] mkw(input int base, input int r, input int k);
    return WW'(base + r * 256 + k);
  endfunction

  // One clock: observe registered outputs, drive lanes from producer queues,
  // sample handshakes just before the edge, retire accepted words after it.
  task automatic step();
    @(negedge wr_clk);
    obs_wr   = fifo_wr_en;
    obs_busy = busy;
    obs_gid  = grant_id;
    obs_din  = fifo_din;
    reset     = reset_drv;
    fifo_full = full_drv;
    for (int i = 0; i < NR; i++) begin
      if (pq[i].size() > 0) begin
        req_valid[i]           = 1'b1;
        req_data[i*WW +: WW]   = pq[i][0].d;
        req_last[i]            = pq[i][0].l;
      end else begin
        req_valid[i]           = 1'b0;
        req_data[i*WW +: WW]   = '0;
        req_last[i]            = 1'b0;
      end
    end
    #4;
    obs_rdy = req_ready;
    xfer    = req_valid & req_ready;
    @(posedge wr_clk);
    for (int i = 0; i < NR; i++) begin
      if (xfer[i]) void'(pq[i].pop_front());
    end
  endtask

  // Scoreboard monitor.
  always @(negedge wr_clk) begin
    exp_t e;
    if (fifo_wr_en === 1'b1) begin
      wr_count++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_write: got id %0d data %0h expected no write", grant_id, fifo_din);
      end else begin
        e = exp_q.pop_front();
        if (fifo_din !== e.d || grant_id !== e.id) begin
          errors++;
          $display("FAIL sb_write: got id %0d data %0h expected id %0d data %0h",
                   grant_id, fifo_din, e.id, e.d);
        end
      end
    end
  end

  initial begin
    int base;
    int acc;
    int full_left;
    bit full_used;
    int first_wr, last_wr, busy_n, gid_ok;
    int j;
    int guard;
    logic       busy_h[16];
    logic [1:0] gid_h[16];

    reset     = 1'b1;
    fifo_full = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;

    // S0: reset with all requesters valid, then full round-robin sweep.
    for (int i = 0; i < NR; i++)
      for (int k = 0; k < S0_WORDS; k++) add_word(i, mkw(16'h1000, i, k), 1'b0);
`ifdef FIFO_ARB_BURST_EN
    for (int i = 0; i < NR; i++)
      for (int k = 0; k < S0_WORDS; k++) expect_wr(i, mkw(16'h1000, i, k));
`else
    for (int k = 0; k < S0_WORDS; k++)
      for (int i = 0; i < NR; i++) expect_wr(i, mkw(16'h1000, i, k));
`endif
    step();
    for (int c = 0; c < 2; c++) begin
      step();
      chk("rst_wr_en", obs_wr, 0);
      chk("rst_din", obs_din, 0);
      chk("rst_grant_id", obs_gid, 0);
      chk("rst_busy", obs_busy, 0);
      chk("rst_req_ready", obs_rdy, 0);
    end
    reset_drv = 1'b0;
    base = wr_count;
    step();
    step();
    chk("first_grant_id", obs_gid, 0);
    chk("first_busy", obs_busy, 1);
    chk("first_wr_not_early", obs_wr, 0);
    step();
    chk("first_wr_en_latency", obs_wr, 1);
    for (int c = 3; c < S0_STEPS; c++) step();
    chk("sweep_write_count", wr_count - base, NR * S0_WORDS);
    step();
    step();
    chk("sweep_no_extra", wr_count - base, NR * S0_WORDS);

    // S1: requester 2 sends three words, last on the third.
    add_word(2, 16'h00A1, 1'b0);
    add_word(2, 16'h00A2, 1'b0);
    add_word(2, 16'h00A3, 1'b1);
    expect_wr(2, 16'h00A1);
    expect_wr(2, 16'h00A2);
    expect_wr(2, 16'h00A3);
    first_wr = -1; last_wr = -1; busy_n = 0; gid_ok = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (obs_busy) begin
        busy_n++;
        if (obs_gid == 2'd2) gid_ok++;
      end
      if (obs_wr) begin
        if (first_wr < 0) first_wr = c;
        last_wr = c;
      end
    end
    chk("r2_busy_cycles", busy_n, 3);
    chk("r2_grant_id", gid_ok, 3);
    chk("r2_write_span", last_wr - first_wr, S1_SPAN);

    // S2: full raised after three accepted words and held five cycles.
    base = wr_count;
    for (int k = 0; k < 8; k++) begin
      add_word(1, mkw(16'h2000, 0, k), 1'b0);
      expect_wr(1, mkw(16'h2000, 0, k));
    end
    acc = 0; full_left = 0; full_used = 0;
    for (int c = 0; c < 40; c++) begin
      if (acc == 3 && !full_used) begin
        full_left = 5;
        full_used = 1;
      end
      full_drv = (full_left > 0);
      step();
      if (full_drv) begin
        chk("full_req_ready", obs_rdy, 0);
        chk("full_grant_id", obs_gid, 1);
        if (full_left == 5) chk("full_last_write", obs_wr, 1);
        else                chk("full_wr_en", obs_wr, 0);
        full_left--;
      end
      acc += int'(xfer[1]);
    end
    full_drv = 1'b0;
    chk("full_total_accepts", acc, 8);
    chk("full_total_writes", wr_count - base, 8);

    // S3: owner 1 drops valid after two words while requester 3 waits.
    add_word(1, 16'h3100, 1'b0);
    add_word(1, 16'h3101, 1'b0);
`ifdef FIFO_ARB_BURST_EN
    expect_wr(1, 16'h3100);
    expect_wr(1, 16'h3101);
    expect_wr(3, 16'h3300);
    expect_wr(3, 16'h3301);
`else
    expect_wr(1, 16'h3100);
    expect_wr(3, 16'h3300);
    expect_wr(1, 16'h3101);
    expect_wr(3, 16'h3301);
`endif
    step();
    busy_h[0] = obs_busy;
    gid_h[0]  = obs_gid;
    add_word(3, 16'h3300, 1'b0);
    add_word(3, 16'h3301, 1'b1);
    for (int c = 1; c < 16; c++) begin
      step();
      busy_h[c] = obs_busy;
      gid_h[c]  = obs_gid;
    end
    j = -1;
    for (int c = 0; c < 16; c++)
      if (j < 0 && busy_h[c] && gid_h[c] == 2'd3) j = c;
    chk("drop_grant3_found", 32'(j >= 2), 1);
    if (j >= 2) begin
      chk("drop_idle_gap", busy_h[j-1], 0);
      chk("drop_prev_busy", busy_h[j-2], 1);
      chk("drop_prev_owner", gid_h[j-2], 1);
    end

    // S4: reset asserted mid-burst.
    for (int k = 0; k < 6; k++) begin
      add_word(0, mkw(16'h4000, 0, k), 1'b0);
      expect_wr(0, mkw(16'h4000, 0, k));
    end
    base  = wr_count;
    guard = 0;
    while (wr_count - base < 2 && guard < 20) begin
      step();
      guard++;
    end
    chk("midrst_progress", 32'(wr_count - base >= 2), 1);
    reset_drv = 1'b1;
    step();
    step();
    chk("midrst_wr_en", obs_wr, 0);
    chk("midrst_busy", obs_busy, 0);
    chk("midrst_grant_id", obs_gid, 0);
    chk("midrst_req_ready", obs_rdy, 0);
    exp_q.delete();
    for (int i = 0; i < NR; i++) pq[i].delete();
    base = wr_count;
    reset_drv = 1'b0;
    for (int c = 0; c < 4; c++) step();
    chk("midrst_no_write", wr_count - base, 0);

    chk("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-side arbiter that shares the write port of one simulation FIFO between `NUM_REQ` producers in the emulation shell. It sits in the FIFO's write clock domain. It grants one requester at a time for a bounded burst and drives the FIFO `wr_en`/`din` from a registered stage. It also throttles every producer on `full`.

## Interface
- `NUM_REQ`, 4: number of requesters (2..16).
- `WORD_WIDTH`, 16: data word width; must match the FIFO.
- `REQ_W`, 2: width of the requester index, equal to clog2(`NUM_REQ`).
- `MAX_BURST`, 8: maximum words accepted per grant (1..2^`BURST_W`-1).
- `BURST_W`, 4: width of the burst beat counter.

Ports:
- `wr_clk`  in  1  the single clock for the whole block.
- `reset`  in  1  synchronous, active-high; sampled on rising `wr_clk`.
- `req_valid`  in  `NUM_REQ`  requester i has a word on its data lane.
- `req_data`  in  `NUM_REQ*WORD_WIDTH`  lane i occupies bits [i*WORD_WIDTH +: WORD_WIDTH].
- `req_last`  in  `NUM_REQ`  the word on lane i ends the requester's burst.
- `req_ready`  out  `NUM_REQ`  combinational accept; one-hot or zero.
- `fifo_full`  in  1  `full` flag from the FIFO.
- `fifo_wr_en`  out  1  registered write enable to the FIFO.
- `fifo_din`  out  `WORD_WIDTH`  registered write data to the FIFO.
- `grant_id`  out  `REQ_W`  index of the current or most recent owner.
- `busy`  out  1  high while in GRANT.

## Operation
- Transfer rule: a word moves on lane i in a cycle where `req_valid[i]` and `req_ready[i]` are both high.
- `req_ready[i]` = (state == GRANT) & (owner == i) & !`fifo_full`.
- The state machine has two states, IDLE and GRANT.
- IDLE:
  - If any `req_valid` bit is high, select the first valid requester at or after `last_owner+1`, wrapping modulo `NUM_REQ`.
  - Load `owner` and `grant_id` with that index, clear `beat_cnt`, and go to GRANT.
  - Otherwise stay in IDLE.
- GRANT, each cycle:
  - If `req_valid[owner]`=0: release. Set `last_owner` to `owner` and go to IDLE. Release happens regardless of `fifo_full`.
  - Else if `fifo_full`=1: stall. `beat_cnt` and `owner` are held; the owner is never preempted.
  - Else: accept the word and increment `beat_cnt`. If `req_last[owner]`=1 or `beat_cnt+1`==`MAX_BURST`, release.
- Output stage: every cycle, `fifo_wr_en` <= accept and `fifo_din` <= the owner's lane if accept, otherwise held.
- Full slack: the FIFO raises `full` with at least 3 words of headroom. This covers the one registered stage plus the stall reaction, so no write is ever issued into a full FIFO.
- `NUM_REQ`=1: the arbiter degenerates to pass-through with one IDLE cycle between bursts.

## Timing
- Reset values: state IDLE, `fifo_wr_en`=0, `fifo_din`=0, `grant_id`=0, `busy`=0, `req_ready`=0, `beat_cnt`=0.
- Reset value of `last_owner` is `NUM_REQ`-1, so requester 0 wins first.
- `reset` asserted mid-burst: the next edge forces IDLE. The word accepted on that same edge is discarded and `fifo_wr_en` is 0 after the edge.
- Latency from a request to the first accept is 1 cycle: the IDLE arbitration cycle. The accepted word reaches `fifo_wr_en`/`fifo_din` on the following edge.
- Every release costs exactly one IDLE cycle before the next grant.
- `fifo_full` acts in the same cycle, because `req_ready` depends on it combinationally.
- `req_last` together with the `MAX_BURST` beat in the same cycle: one release.
- `beat_cnt` compares in `BURST_W` bits. It never wraps, because it clears on every grant.

## Configuration
- `FIFO_ARB_BURST_EN` defined: bursts of up to `MAX_BURST` words per grant, as described above.
- `FIFO_ARB_BURST_EN` undefined: every accepted word releases the grant. `req_last` and `MAX_BURST` are ignored and `beat_cnt` is not built. Throughput is one word per two cycles.

## Structure
- Shared package `fifo_arb_pkg` holds:
  - the state encoding localparams `ST_IDLE`=1'b0 and `ST_GRANT`=1'b1;
  - a function that returns the clog2 used for `REQ_W`.
- One combinational sub-module, `rr_arb_pick`:
  - inputs: the `req_valid` vector and `last_owner`;
  - outputs: the `pick` index and an `any` flag.
- All state lives in `fifo_wr_arbiter`.

## Test plan
- Reset held 2 cycles while all `req_valid` bits are high -> all outputs 0 during reset. Then `grant_id`=0 and the first `fifo_wr_en` appears 2 cycles after reset is released.
- Requester 2 sends 3 words 0xA1, 0xA2, 0xA3 with `req_last` on the third -> `grant_id`=2, `busy` high for 3 cycles, `fifo_wr_en` high for 3 consecutive cycles with those words in order, then IDLE.
- All 4 requesters valid continuously, burst enabled, `MAX_BURST`=8 -> owner sequence 0,1,2,3,0; 8 words each; 32 writes in 36 cycles.
- `fifo_full` raised after 3 accepted words and held 5 cycles -> `req_ready`=0 and `fifo_wr_en`=0 from the next edge, owner unchanged. The remaining 5 words follow once full drops.
- Owner 1 drops `req_valid` after 2 words while requester 3 is pending -> release, one IDLE cycle, then `grant_id`=3.
- Macro undefined, 4 requesters valid -> one word each in order 0,1,2,3,0 with `fifo_wr_en` toggling every other cycle.
